// File: rtl/otbn_ntt_addr_seq.sv
// otbn_ntt_addr_seq: autonomous NTT/INTT butterfly address sequencer.
// Walks every (stage, pair) of an IdxW-stage transform and presents one
// (idx0, idx1, twiddle) triple per cycle to the butterfly datapath under
// valid/ready. Mode 0 = Cooley-Tukey forward order, mode 1 = Gentleman-Sande
// inverse order. Configuration and status are exposed on the PQ ISPR port.
// Optional feature macro: OTBN_ADDR_SEQ_LAYER_LIMIT_EN enables a writable
// IsprSeqCfg register that restricts a run to a sub-range of stages.

package otbn_ntt_addr_seq_pkg;
    typedef enum logic [2:0] {
        IsprMode   = 3'd0,
        IsprIdx0   = 3'd1,
        IsprIdx1   = 3'd2,
        IsprJ      = 3'd3,
        IsprSeqCfg = 3'd4
    } ipqspr_e;
endpackage

// state   | meaning
// --------+---------------------------------------------------------------
// StIdle  | no run active; start_i launches a run, ISPR writes accepted
// StRun   | presenting triples; p advances per handshake, s per stage
module otbn_ntt_addr_seq
    import otbn_ntt_addr_seq_pkg::*;
#(
    parameter int IdxW  = 8,
    parameter int WselW = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [IdxW-WselW-1:0]      wdr0_o,
    output logic [WselW-1:0]           wsel0_o,
    output logic [IdxW-WselW-1:0]      wdr1_o,
    output logic [WselW-1:0]           wsel1_o,
    output logic [IdxW-1:0]            tw_idx_o,
    output logic [$clog2(IdxW)-1:0]    stage_o,
    input  ipqspr_e                    ispr_addr_i,
    input  logic [31:0]                ispr_base_wdata_i,
    input  logic [7:0]                 ispr_base_wr_en_i,
    input  logic                       ispr_init_i,
    output logic [31:0]                ispr_rdata_o
);

    localparam int SW = $clog2(IdxW);
    localparam int PW = IdxW - 1;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    state_e          state_q;
    logic [SW-1:0]   s_q;
    logic [PW-1:0]   p_q;
    logic            mode_q;
    logic            run_mode_q;
    logic            done_q;
    logic [SW-1:0]   cfg_first;
    logic [SW-1:0]   cfg_last;
    logic            ispr_wr;

    logic [SW-1:0]   lsh;
    logic [IdxW-1:0] p_ext;
    logic [IdxW-1:0] low_mask;
    logic [IdxW-1:0] idx0_raw;
    logic [IdxW-1:0] idx1_raw;
    logic [IdxW-1:0] grp;
    logic [IdxW-1:0] tw_raw;
    logic [IdxW-1:0] idx0;
    logic [IdxW-1:0] idx1;
    logic [IdxW-1:0] tw;
    logic            running;

    assign running = (state_q == StRun);
    assign ispr_wr = (|ispr_base_wr_en_i) && (state_q == StIdle);

`ifdef OTBN_ADDR_SEQ_LAYER_LIMIT_EN
    logic [SW-1:0] cfg_first_q;
    logic [SW-1:0] cfg_last_q;
    logic          unused_wdata;

    assign cfg_first    = cfg_first_q;
    assign cfg_last     = cfg_last_q;
    assign unused_wdata = ^ispr_base_wdata_i[31:8];

    // Out-of-range stage numbers clamp to the last stage.
    function automatic logic [SW-1:0] sat_stage(input logic [3:0] v);
        if (int'(v) > IdxW - 1) return SW'(IdxW - 1);
        return SW'(v);
    endfunction

    // Stage-range configuration register, writable only while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_first_q <= '0;
            cfg_last_q  <= SW'(IdxW - 1);
        end else if (ispr_init_i) begin
            cfg_first_q <= '0;
            cfg_last_q  <= SW'(IdxW - 1);
        end else if (ispr_wr && ispr_addr_i == IsprSeqCfg) begin
            cfg_first_q <= sat_stage(ispr_base_wdata_i[3:0]);
            cfg_last_q  <= sat_stage(ispr_base_wdata_i[7:4]);
        end
    end
`else
    logic unused_wdata;

    assign cfg_first    = '0;
    assign cfg_last     = SW'(IdxW - 1);
    assign unused_wdata = ^ispr_base_wdata_i[31:1];
`endif

    // Sequencer FSM: stage/pair counters, run mode capture and done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            s_q        <= '0;
            p_q        <= '0;
            mode_q     <= 1'b0;
            run_mode_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (ispr_init_i) begin
            state_q    <= StIdle;
            s_q        <= '0;
            p_q        <= '0;
            mode_q     <= 1'b0;
            run_mode_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ispr_wr && ispr_addr_i == IsprMode) begin
                mode_q <= ispr_base_wdata_i[0];
            end
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        run_mode_q <= mode_q;
                        p_q        <= '0;
                        if (cfg_first > cfg_last) begin
                            // Empty stage range: finish without presenting anything.
                            s_q    <= '0;
                            done_q <= 1'b1;
                        end else begin
                            s_q     <= cfg_first;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (ready_i) begin
                        if (&p_q) begin
                            p_q <= '0;
                            if (s_q == cfg_last) begin
                                s_q     <= '0;
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end else begin
                                s_q <= s_q + SW'(1);
                            end
                        end else begin
                            p_q <= p_q + PW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Butterfly addressing: split p at bit L, insert the pair-select bit there.
    always_comb begin
        lsh      = run_mode_q ? s_q : (SW'(IdxW - 1) - s_q);
        p_ext    = {1'b0, p_q};
        low_mask = (IdxW'(1) << lsh) - IdxW'(1);
        idx0_raw = ((p_ext & ~low_mask) << 1) | (p_ext & low_mask);
        idx1_raw = idx0_raw | (IdxW'(1) << lsh);
        grp      = p_ext >> lsh;
        tw_raw   = ((IdxW'(1) << (IdxW - 1)) >> lsh) + grp;
        idx0     = running ? idx0_raw : '0;
        idx1     = running ? idx1_raw : '0;
        tw       = running ? tw_raw   : '0;
    end

    // ISPR read mux; unmapped selects read as zero.
    always_comb begin
        ispr_rdata_o = '0;
        case (ispr_addr_i)
            IsprMode:   ispr_rdata_o = {31'b0, mode_q};
            IsprIdx0:   ispr_rdata_o = 32'(idx0);
            IsprIdx1:   ispr_rdata_o = 32'(idx1);
            IsprJ:      ispr_rdata_o = 32'(p_q);
`ifdef OTBN_ADDR_SEQ_LAYER_LIMIT_EN
            IsprSeqCfg: ispr_rdata_o = {24'b0, 4'(cfg_last), 4'(cfg_first)};
`endif
            default:    ispr_rdata_o = '0;
        endcase
    end

    assign busy_o   = running;
    assign valid_o  = running;
    assign done_o   = done_q;
    assign stage_o  = s_q;
    assign tw_idx_o = tw;
    assign wdr0_o   = idx0[IdxW-1:WselW];
    assign wsel0_o  = idx0[WselW-1:0];
    assign wdr1_o   = idx1[IdxW-1:WselW];
    assign wsel1_o  = idx1[WselW-1:0];

endmodule

// File: tb/tb_otbn_ntt_addr_seq.sv
// Testbench for otbn_ntt_addr_seq (IdxW=8, WselW=3): golden-model scoreboard
// plus hand-computed spot vectors, stall stability, ISPR and abort behaviour.
module tb_otbn_ntt_addr_seq;
    import otbn_ntt_addr_seq_pkg::*;

    localparam int IdxW = 8;
    localparam int N    = 1 << IdxW;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, valid_o;
    logic        ready_i = 1'b1;
    logic [4:0]  wdr0_o, wdr1_o;
    logic [2:0]  wsel0_o, wsel1_o;
    logic [7:0]  tw_idx_o;
    logic [2:0]  stage_o;
    ipqspr_e     ispr_addr_i = IsprMode;
    logic [31:0] ispr_base_wdata_i = '0;
    logic [7:0]  ispr_base_wr_en_i = '0;
    logic        ispr_init_i = 1'b0;
    logic [31:0] ispr_rdata_o;

    otbn_ntt_addr_seq #(.IdxW(8), .WselW(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o),
        .done_o(done_o), .valid_o(valid_o), .ready_i(ready_i),
        .wdr0_o(wdr0_o), .wsel0_o(wsel0_o), .wdr1_o(wdr1_o), .wsel1_o(wsel1_o),
        .tw_idx_o(tw_idx_o), .stage_o(stage_o), .ispr_addr_i(ispr_addr_i),
        .ispr_base_wdata_i(ispr_base_wdata_i), .ispr_base_wr_en_i(ispr_base_wr_en_i),
        .ispr_init_i(ispr_init_i), .ispr_rdata_o(ispr_rdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { int i0; int i1; int tw; int st; } trip_t;
    typedef struct packed { int hs; int i0; int i1; int tw; int wdr; int wsel; } dir_t;

    trip_t sb[$];
    dir_t  dq[$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0;
    int hs_count = 0, stall_cnt = 0, valid_cnt = 0, done_cnt = 0;
    bit first_seen = 0;
    bit stall_en = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference order written as the textbook nested NTT loops.
    task automatic push_golden(input int mode, input int first, input int last);
        for (int s = first; s <= last; s++) begin
            int lg, len, ngrp;
            lg   = (mode != 0) ? s : (IdxW - 1 - s);
            len  = 1 << lg;
            ngrp = N / (2 * len);
            for (int g = 0; g < ngrp; g++) begin
                for (int j = 0; j < len; j++) begin
                    trip_t t;
                    t.i0 = g * 2 * len + j;
                    t.i1 = t.i0 + len;
                    t.tw = (N / 2) / len + g;
                    t.st = s;
                    sb.push_back(t);
                end
            end
        end
    endtask

    task automatic push_dir(input int hs, input int i0, input int i1, input int tw,
                            input int wdr, input int wsel);
        dir_t d;
        d.hs = hs; d.i0 = i0; d.i1 = i1; d.tw = tw; d.wdr = wdr; d.wsel = wsel;
        dq.push_back(d);
    endtask

    // Ready driver: always ready, or randomly stalling when enabled.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            ready_i = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on each accepted triple, checks held triples.
    initial begin
        bit held_v;
        int held_val;
        held_v = 0;
        held_val = 0;
        forever begin
            int a0, a1, cur;
            @(negedge clk_i);
            a0  = int'({wdr0_o, wsel0_o});
            a1  = int'({wdr1_o, wsel1_o});
            cur = (a0 << 24) | (a1 << 16) | (int'(tw_idx_o) << 8) | int'(stage_o);
            if (done_o) done_cnt++;
            if (valid_o) valid_cnt++;
            if (valid_o && !first_seen) begin
                first_seen = 1;
                check("first_valid_cycle", cyc - start_cyc, 1);
            end
            if (held_v && valid_o) check("stall_hold", cur, held_val);
            held_v   = valid_o && !ready_i && !ispr_init_i;
            held_val = cur;
            if (valid_o && !ready_i && !ispr_init_i) stall_cnt++;
            if (valid_o && ready_i && !ispr_init_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got handshake %0d, expected none", hs_count);
                end else begin
                    trip_t e;
                    e = sb.pop_front();
                    check("idx0", a0, e.i0);
                    check("idx1", a1, e.i1);
                    check("tw_idx", int'(tw_idx_o), e.tw);
                    check("stage", int'(stage_o), e.st);
                end
                if (dq.size() != 0 && dq[0].hs == hs_count) begin
                    dir_t d;
                    d = dq.pop_front();
                    check("dir_idx0", a0, d.i0);
                    check("dir_idx1", a1, d.i1);
                    check("dir_tw", int'(tw_idx_o), d.tw);
                    check("dir_wdr0", int'(wdr0_o), d.wdr);
                    check("dir_wsel0", int'(wsel0_o), d.wsel);
                end
                hs_count++;
            end
        end
    end

    // All stimulus tasks operate one time unit after a rising edge.
    task automatic start_run();
        start_i    = 1'b1;
        start_cyc  = cyc;
        hs_count   = 0;
        stall_cnt  = 0;
        first_seen = 0;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int exp_hs);
        int k;
        k = 0;
        while (!done_o && k < 4000) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        if (!done_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done_o, expected done after %0d handshakes", exp_hs);
        end else begin
            check("done_cycle", cyc - start_cyc, 1 + exp_hs + stall_cnt);
            check("handshakes", hs_count, exp_hs);
            check("busy_at_done", int'(busy_o), 0);
            check("sb_drained", sb.size(), 0);
            check("dir_drained", dq.size(), 0);
        end
    endtask

    task automatic ispr_write(input ipqspr_e a, input int d);
        ispr_addr_i       = a;
        ispr_base_wdata_i = d;
        ispr_base_wr_en_i = 8'h01;
        @(posedge clk_i);
        #1;
        ispr_base_wr_en_i = '0;
    endtask

    task automatic ispr_read(input string name, input ipqspr_e a, input int exp);
        ispr_addr_i = a;
        #1;
        check(name, int'(ispr_rdata_o), exp);
    endtask

    initial begin
        int dcnt, vcnt;
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish within 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt, vcnt;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_idx0", int'({wdr0_o, wsel0_o}), 0);
        check("rst_idx1", int'({wdr1_o, wsel1_o}), 0);
        check("rst_tw", int'(tw_idx_o), 0);
        check("rst_stage", int'(stage_o), 0);
        check("rst_mode_rd", int'(ispr_rdata_o), 0);
        @(posedge clk_i);
        #1;

        // Run A: forward order, no stalls.
        push_golden(0, 0, IdxW - 1);
        push_dir(0, 0, 128, 1, 0, 0);
        push_dir(127, 127, 255, 1, 15, 7);
        push_dir(198, 134, 198, 3, 16, 6);
        push_dir(901, 10, 11, 133, 1, 2);
        start_run();
        wait_done(1024);
        check("done_cycle_abs", cyc - start_cyc, 1025);
        @(posedge clk_i);
        #1;

        // Run B: inverse order with random stalls; mode write mid-run ignored.
        ispr_write(IsprMode, 1);
        ispr_read("mode_rd_1", IsprMode, 1);
        push_golden(1, 0, IdxW - 1);
        push_dir(5, 10, 11, 133, 1, 2);
        push_dir(896, 0, 128, 1, 0, 0);
        stall_en = 1;
        start_run();
        repeat (50) @(posedge clk_i);
        #1;
        ispr_write(IsprMode, 0);
        wait_done(1024);
        stall_en = 0;
        ispr_read("mode_after_busy_wr", IsprMode, 1);

        // Run C: started in the done cycle, aborted by ispr_init_i at pair 300.
        push_golden(1, 0, IdxW - 1);
        start_run();
        while (cyc - start_cyc < 301) begin
            @(posedge clk_i);
            #1;
        end
        ispr_init_i = 1'b1;
        ispr_read("j_mid_run", IsprJ, 44);
        ispr_read("idx0_mid_run", IsprIdx0, 88);
        ispr_read("idx1_mid_run", IsprIdx1, 92);
        dcnt = done_cnt;
        @(posedge clk_i);
        #1;
        ispr_init_i = 1'b0;
        check("init_hs", hs_count, 300);
        sb.delete();
        check("init_busy", int'(busy_o), 0);
        check("init_valid", int'(valid_o), 0);
        check("init_stage", int'(stage_o), 0);
        ispr_read("init_j", IsprJ, 0);
        ispr_read("init_mode", IsprMode, 0);
        repeat (5) @(posedge clk_i);
        #1;
        check("init_no_done", done_cnt, dcnt);

`ifdef OTBN_ADDR_SEQ_LAYER_LIMIT_EN
        ispr_read("cfg_init_rd", IsprSeqCfg, 32'h70);
        ispr_write(IsprSeqCfg, 32'h9F);
        ispr_read("cfg_saturate", IsprSeqCfg, 32'h77);
        ispr_write(IsprSeqCfg, 32'h76);
        ispr_read("cfg_rd", IsprSeqCfg, 32'h76);
        push_golden(0, 6, 7);
        push_dir(0, 0, 2, 64, 0, 0);
        start_run();
        wait_done(256);
        @(posedge clk_i);
        #1;
        ispr_write(IsprSeqCfg, 32'h25);
        vcnt = valid_cnt;
        start_run();
        wait_done(0);
        @(posedge clk_i);
        #1;
        check("empty_range_no_valid", valid_cnt, vcnt);
        ispr_init_i = 1'b1;
        @(posedge clk_i);
        #1;
        ispr_init_i = 1'b0;
        ispr_read("cfg_after_init", IsprSeqCfg, 32'h70);
`else
        ispr_write(IsprSeqCfg, 32'h76);
        ispr_read("cfg_reads_zero", IsprSeqCfg, 0);
`endif

        // Reset mid-run: back to idle, no done pulse.
        push_golden(0, 0, IdxW - 1);
        start_run();
        repeat (20) @(posedge clk_i);
        #1;
        dcnt = done_cnt;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_busy", int'(busy_o), 0);
        check("rst_mid_valid", int'(valid_o), 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        sb.delete();
        repeat (5) @(posedge clk_i);
        #1;
        check("rst_mid_no_done", done_cnt, dcnt);
        check("rst_mid_idle", int'(busy_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
